// File: rtl/stopwatch_button_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stopwatch_button_ctrl_if : raw button inputs and command outputs of the
// stopwatch button front end.                                    Rev 1.0
// ----------------------------------------------------------------------------
interface stopwatch_button_ctrl_if;
  logic       pb_start_stop;
  logic       pb_lap_reset;
  logic       de_start_stop;
  logic       de_lap_reset;
  logic [2:0] reset;

  modport master (
    output pb_start_stop, pb_lap_reset,
    input  de_start_stop, de_lap_reset, reset
  );

  modport slave (
    input  pb_start_stop, pb_lap_reset,
    output de_start_stop, de_lap_reset, reset
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_button_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stopwatch_button_ctrl : synchronise/debounce two buttons into command pulses.
// Define LONG_PRESS_RESET_EN for long-press reset detection.      Rev 1.0
// ----------------------------------------------------------------------------
module stopwatch_button_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int LONG_CYC     = 200
) (
  input  wire logic              clk_100,
  input  wire logic              rst,
  stopwatch_button_ctrl_if.slave btn
);

  localparam logic [3:0] C_DB_LAST = 4'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 15 ||
      LONG_CYC <= DEBOUNCE_CYC || LONG_CYC > 255) begin : g_param_check
    $error("stopwatch_button_ctrl: DEBOUNCE_CYC/LONG_CYC out of range");
  end

  logic [1:0] raw_btn;
  logic [1:0] level;
  logic [1:0] level_d;
  logic [1:0] rise;

  assign raw_btn = {btn.pb_lap_reset, btn.pb_start_stop};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic       sync_a;
    logic       sync_b;
    logic       deb;
    logic [3:0] stable_cnt;

    always_ff @(posedge clk_100) begin
      if (rst) begin
        sync_a     <= 1'b0;
        sync_b     <= 1'b0;
        deb        <= 1'b0;
        stable_cnt <= 4'd0;
      end else begin
        sync_a <= raw_btn[i];
        sync_b <= sync_a;
        // A new level is accepted only after DEBOUNCE_CYC consecutive differing samples
        if (sync_b == deb) begin
          stable_cnt <= 4'd0;
        end else if (stable_cnt == C_DB_LAST) begin
          deb        <= ~deb;
          stable_cnt <= 4'd0;
        end else begin
          stable_cnt <= stable_cnt + 4'd1;
        end
      end
    end

    assign level[i] = deb;
  end

  assign rise = level & ~level_d;

  logic ss_pulse;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      level_d  <= 2'b00;
      ss_pulse <= 1'b0;
    end else begin
      level_d  <= level;
      ss_pulse <= rise[0];
    end
  end

  assign btn.de_start_stop = ss_pulse;

`ifdef LONG_PRESS_RESET_EN
  localparam logic [7:0] C_LONG_LAST = 8'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } lap_state_t;

  lap_state_t state;
  logic [7:0] hold_cnt;
  logic       lap_pulse;
  logic [2:0] reset_code;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= 8'd0;
      lap_pulse  <= 1'b0;
      reset_code <= 3'd0;
    end else begin
      lap_pulse  <= 1'b0;
      reset_code <= 3'd0;
      case (state)
        ST_IDLE: begin
          if (rise[1]) begin
            state    <= ST_HELD;
            hold_cnt <= 8'd1;
          end
        end
        ST_HELD: begin
          if (!level[1]) begin
            state     <= ST_IDLE;
            lap_pulse <= 1'b1;
          end else if (hold_cnt == C_LONG_LAST) begin
            state      <= ST_LONG;
            hold_cnt   <= hold_cnt + 8'd1;
            reset_code <= 3'd2;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        // Counter stays frozen here so a very long hold never re-fires
        ST_LONG: begin
          if (!level[1]) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign btn.de_lap_reset = lap_pulse;
  assign btn.reset        = reset_code;
`else
  logic lap_pulse;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      lap_pulse <= 1'b0;
    end else begin
      lap_pulse <= rise[1];
    end
  end

  assign btn.de_lap_reset = lap_pulse;
  assign btn.reset        = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_button_ctrl.sv
`default_nettype none
// Testbench for stopwatch_button_ctrl: directed scenarios plus randomized
// stimulus against a cycle-indexed behavioural model of the button rules.
module tb_stopwatch_button_ctrl;
  localparam int DEB  = 4;
  localparam int LONG = 200;
  localparam int N    = 8192;

  logic clk_100 = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_100 = ~clk_100;

  stopwatch_button_ctrl_if bif();

  stopwatch_button_ctrl #(.DEBOUNCE_CYC(DEB), .LONG_CYC(LONG)) dut (
    .clk_100 (clk_100),
    .rst     (rst),
    .btn     (bif.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Cycle-indexed history: inputs seen before edge n, debounced level after edge n
  bit raw_h [2][N];
  bit rst_h [N];
  bit lvl_h [2][N];
  int n = 8;
`ifdef LONG_PRESS_RESET_EN
  int press_r = -1;
`endif

  bit         e_ss;
  bit         e_lap;
  logic [2:0] e_rst;

  // Synchronised sample the debouncer sees at edge m: raw value two edges earlier
  function automatic bit samp(int b, int m);
    if (rst_h[m-1] || rst_h[m-2]) return 1'b0;
    return raw_h[b][m-2];
  endfunction

  task automatic tick();
    bit prev;
    bit flip;
    if (n >= N - 1) begin
      $display("FAIL model_history: cycle %0d exceeds history size %0d", n, N);
      $fatal(1);
    end
    raw_h[0][n] = bif.pb_start_stop;
    raw_h[1][n] = bif.pb_lap_reset;
    rst_h[n]    = rst;
    @(posedge clk_100);
    #1;
    for (int b = 0; b < 2; b++) begin
      prev = lvl_h[b][n-1];
      if (rst_h[n]) begin
        lvl_h[b][n] = 1'b0;
      end else begin
        flip = 1'b1;
        for (int j = n - DEB + 1; j <= n; j++)
          if (rst_h[j] || samp(b, j) == prev) flip = 1'b0;
        lvl_h[b][n] = flip ? !prev : prev;
      end
    end
    e_ss = !rst_h[n] && lvl_h[0][n-1] && !lvl_h[0][n-2];
`ifdef LONG_PRESS_RESET_EN
    e_lap = 1'b0;
    e_rst = 3'd0;
    if (rst_h[n]) begin
      press_r = -1;
    end else if (lvl_h[1][n-1] && !lvl_h[1][n-2]) begin
      press_r = n - 1;
    end else if (!lvl_h[1][n-1] && lvl_h[1][n-2]) begin
      e_lap   = (press_r >= 0) && ((n - 1 - press_r) < LONG);
      press_r = -1;
    end else if (press_r >= 0 && (n - press_r) == LONG) begin
      e_rst = 3'd2;
    end
`else
    e_lap = !rst_h[n] && lvl_h[1][n-1] && !lvl_h[1][n-2];
    e_rst = 3'd0;
`endif
    n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bif.pb_start_stop = 1'($urandom);
      bif.pb_lap_reset  = 1'($urandom);
      tick();
      vectors++;
      if (bif.de_start_stop !== 1'b0 || bif.de_lap_reset !== 1'b0 || bif.reset !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc %0d: ss=%b lap=%b reset=%0d, expected all 0",
                 i, bif.de_start_stop, bif.de_lap_reset, bif.reset);
      end
    end
    rst = 1'b0;
    bif.pb_start_stop = 1'b0;
    bif.pb_lap_reset  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (bif.de_start_stop !== e_ss || bif.de_lap_reset !== e_lap || bif.reset !== e_rst) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: ss=%b lap=%b reset=%0d, expected ss=%b lap=%b reset=%0d",
                 i, bif.de_start_stop, bif.de_lap_reset, bif.reset, e_ss, e_lap, e_rst);
      end
    end
  endtask

  task automatic test_clean_press();
    int first  = -1;
    int pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      bif.pb_start_stop = (i <= 10);
      tick();
      vectors++;
      if (bif.de_start_stop !== e_ss || bif.de_lap_reset !== e_lap || bif.reset !== e_rst) begin
        miscompares++;
        $display("FAIL clean_press cyc %0d: ss=%b lap=%b reset=%0d, expected ss=%b lap=%b reset=%0d",
                 i, bif.de_start_stop, bif.de_lap_reset, bif.reset, e_ss, e_lap, e_rst);
      end
      if (bif.de_start_stop === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL clean_press_count: %0d pulses, expected 1", pulses);
    end
    vectors++;
    if (first != DEB + 3) begin
      miscompares++;
      $display("FAIL clean_press_latency: pulse at cycle %0d, expected %0d", first, DEB + 3);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      bif.pb_start_stop = (i <= 20) && (((i - 1) / 2) % 2 == 0);
      tick();
      vectors++;
      if (bif.de_start_stop !== e_ss || bif.de_lap_reset !== e_lap || bif.reset !== e_rst) begin
        miscompares++;
        $display("FAIL bounce cyc %0d: ss=%b lap=%b reset=%0d, expected ss=%b lap=%b reset=%0d",
                 i, bif.de_start_stop, bif.de_lap_reset, bif.reset, e_ss, e_lap, e_rst);
      end
      if (bif.de_start_stop === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL bounce_count: %0d pulses, expected 0", pulses);
    end
  endtask

  task automatic test_lap_press(input string name, input int hold, input int cycles,
                                input int exp_laps, input int exp_rst_at);
    int laps = 0;
    int rsts = 0;
    int rst_at = -1;
    for (int i = 1; i <= cycles; i++) begin
      bif.pb_lap_reset = (i <= hold);
      tick();
      vectors++;
      if (bif.de_start_stop !== e_ss || bif.de_lap_reset !== e_lap || bif.reset !== e_rst) begin
        miscompares++;
        $display("FAIL %s cyc %0d: ss=%b lap=%b reset=%0d, expected ss=%b lap=%b reset=%0d",
                 name, i, bif.de_start_stop, bif.de_lap_reset, bif.reset, e_ss, e_lap, e_rst);
      end
      if (bif.de_lap_reset === 1'b1) laps++;
      if (bif.reset !== 3'd0) begin
        rsts++;
        rst_at = i;
      end
    end
    vectors++;
    if (laps != exp_laps) begin
      miscompares++;
      $display("FAIL %s_lap_count: %0d pulses, expected %0d", name, laps, exp_laps);
    end
    vectors++;
    if (rst_at != exp_rst_at || rsts != (exp_rst_at > 0 ? 1 : 0)) begin
      miscompares++;
      $display("FAIL %s_reset_code: %0d pulses last at %0d, expected at %0d",
               name, rsts, rst_at, exp_rst_at);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int pulses = 0;
    int rst_at = -1;
    for (int i = 1; i <= 330; i++) begin
      bif.pb_start_stop = (i <= 300);
      bif.pb_lap_reset  = (i <= 300);
      tick();
      vectors++;
      if (bif.de_start_stop !== e_ss || bif.de_lap_reset !== e_lap || bif.reset !== e_rst) begin
        miscompares++;
        $display("FAIL both cyc %0d: ss=%b lap=%b reset=%0d, expected ss=%b lap=%b reset=%0d",
                 i, bif.de_start_stop, bif.de_lap_reset, bif.reset, e_ss, e_lap, e_rst);
      end
      if (bif.de_start_stop === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (bif.reset === 3'd2) rst_at = i;
    end
    vectors++;
    if (pulses != 1 || first != DEB + 3) begin
      miscompares++;
      $display("FAIL both_ss: %0d pulses first at %0d, expected 1 at %0d", pulses, first, DEB + 3);
    end
`ifdef LONG_PRESS_RESET_EN
    vectors++;
    if (rst_at != DEB + 2 + LONG) begin
      miscompares++;
      $display("FAIL both_reset: reset code at %0d, expected %0d", rst_at, DEB + 2 + LONG);
    end
`endif
  endtask

  task automatic test_reset_mid_press();
    int laps = 0;
    int rst_at = -1;
    for (int i = 1; i <= 420; i++) begin
      bif.pb_lap_reset = 1'b1;
      rst = (i >= 156 && i <= 158);
      tick();
      vectors++;
      if (bif.de_start_stop !== e_ss || bif.de_lap_reset !== e_lap || bif.reset !== e_rst) begin
        miscompares++;
        $display("FAIL mid_reset cyc %0d: ss=%b lap=%b reset=%0d, expected ss=%b lap=%b reset=%0d",
                 i, bif.de_start_stop, bif.de_lap_reset, bif.reset, e_ss, e_lap, e_rst);
      end
      if (bif.de_lap_reset === 1'b1) laps++;
      if (bif.reset !== 3'd0) rst_at = i;
    end
    rst = 1'b0;
    bif.pb_lap_reset = 1'b0;
`ifdef LONG_PRESS_RESET_EN
    vectors++;
    if (rst_at != 159 + DEB + 1 + LONG || laps != 0) begin
      miscompares++;
      $display("FAIL mid_reset_long: reset at %0d laps %0d, expected reset at %0d laps 0",
               rst_at, laps, 159 + DEB + 1 + LONG);
    end
`else
    vectors++;
    if (rst_at != -1 || laps != 2) begin
      miscompares++;
      $display("FAIL mid_reset_nomacro: reset at %0d laps %0d, expected none and 2", rst_at, laps);
    end
`endif
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_random();
    int left_ss  = 1;
    int left_lap = 1;
    int rst_left = 0;
    bit prev_ss  = 1'b0;
    bit prev_lap = 1'b0;
    bit prev_rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      left_ss--;
      if (left_ss <= 0) begin
        bif.pb_start_stop = !bif.pb_start_stop;
        left_ss = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEB)) : int'($urandom_range(DEB, 40));
      end
      left_lap--;
      if (left_lap <= 0) begin
        bif.pb_lap_reset = !bif.pb_lap_reset;
        left_lap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEB)) : int'($urandom_range(DEB, 260));
      end
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 399) == 0) rst_left = int'($urandom_range(1, 3));
      rst = (rst_left > 0);
      tick();
      vectors++;
      if (bif.de_start_stop !== e_ss || bif.de_lap_reset !== e_lap || bif.reset !== e_rst) begin
        miscompares++;
        $display("FAIL random cyc %0d: ss=%b lap=%b reset=%0d, expected ss=%b lap=%b reset=%0d",
                 i, bif.de_start_stop, bif.de_lap_reset, bif.reset, e_ss, e_lap, e_rst);
      end
      vectors++;
      if ((bif.de_start_stop === 1'b1 && prev_ss) || (bif.de_lap_reset === 1'b1 && prev_lap) ||
          (bif.reset !== 3'd0 && prev_rst)) begin
        miscompares++;
        $display("FAIL random_consecutive cyc %0d: ss=%b lap=%b reset=%0d, expected no repeat of a high output",
                 i, bif.de_start_stop, bif.de_lap_reset, bif.reset);
      end
      prev_ss  = (bif.de_start_stop === 1'b1);
      prev_lap = (bif.de_lap_reset === 1'b1);
      prev_rst = (bif.reset !== 3'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    bif.pb_start_stop = 1'b0;
    bif.pb_lap_reset  = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
`ifdef LONG_PRESS_RESET_EN
    test_lap_press("short_lap", 50, 80, 1, -1);
    test_lap_press("long_lap", 300, 330, 0, DEB + 2 + LONG);
`else
    test_lap_press("short_lap", 50, 80, 1, -1);
    test_lap_press("long_lap", 300, 330, 1, -1);
`endif
    test_back_to_back();
    test_reset_mid_press();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
